// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with per-scan press/release debounce.
// One column is driven low at a time; rows are sampled once per column dwell,
// and a debounce FSM evaluates each complete four-column scan.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat of key_pulse while a
// key stays accepted; without it exactly one key_pulse is produced per press.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] decode,
  output logic       key_valid,
  output logic       key_pulse,
  output logic       key_release
);

  localparam int unsigned   DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_LAST   = 4'(DEBOUNCE_SCANS - 1);
  // An illegal configuration keeps the scanner parked instead of misbehaving.
  localparam bit CFG_OK = (SCAN_DIV >= 4) && (DEBOUNCE_SCANS >= 1) &&
                          (DEBOUNCE_SCANS <= 15) && (REPEAT_SCANS >= 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_PEND = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_PEND   = 2'd3
  } state_t;

  // Column drive pattern to column number.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      4'b1110: col_index = 2'd0;
      4'b1101: col_index = 2'd1;
      4'b1011: col_index = 2'd2;
      4'b0111: col_index = 2'd3;
      default: col_index = 2'd0;
    endcase
  endfunction

  // One-hot active row to row number.
  function automatic logic [1:0] row_index(input logic [3:0] low);
    case (low)
      4'b0001: row_index = 2'd0;
      4'b0010: row_index = 2'd1;
      4'b0100: row_index = 2'd2;
      4'b1000: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

  // Physical key position to hex code.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h4;
      4'b00_10: key_map = 4'h7;
      4'b00_11: key_map = 4'h0;
      4'b01_00: key_map = 4'h2;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h8;
      4'b01_11: key_map = 4'hF;
      4'b10_00: key_map = 4'h3;
      4'b10_01: key_map = 4'h6;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hE;
      4'b11_00: key_map = 4'hA;
      4'b11_01: key_map = 4'hB;
      4'b11_10: key_map = 4'hC;
      4'b11_11: key_map = 4'hD;
      default:  key_map = 4'h0;
    endcase
  endfunction

  logic [1:0]    r_rst_sync;
  logic [3:0]    r_row_meta, r_row_sync;
  logic [DW-1:0] r_dwell;
  logic [3:0]    r_col;
  logic          r_acc_any, r_acc_multi;
  logic [3:0]    r_acc_code;
  logic          r_scan_valid, r_scan_single;
  logic [3:0]    r_scan_code;
  state_t        r_state;
  logic [3:0]    r_cnt, r_cand;
  logic [3:0]    r_decode;
  logic          r_key_valid, r_key_pulse, r_key_release;

  logic          w_run, w_term;
  logic [3:0]    w_low;
  logic          w_first, w_one_low, w_any_prev, w_multi_prev;
  logic          w_acc_any, w_acc_multi;
  logic [3:0]    w_acc_code;
  logic          w_match_cand, w_match_dec;
  state_t        w_state_nxt;
  logic [3:0]    w_cnt_nxt, w_cand_nxt;
  logic          w_accept, w_rel_evt, w_rep_fire;
  logic [3:0]    w_decode_nxt;
  logic          w_valid_nxt, w_pulse_nxt, w_release_nxt;

  // Internal reset release: asserts with rst_n, deasserts two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run  = r_rst_sync[1] & CFG_OK;
  assign w_term = w_run && (r_dwell == DWELL_LAST);

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
    end
  end

  // Dwell counter and column rotation at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_col   <= 4'b1110;
    end else if (w_term) begin
      r_dwell <= '0;
      r_col   <= {r_col[2:0], r_col[3]};
    end else if (w_run) begin
      r_dwell <= r_dwell + DW'(1);
    end else begin
      r_dwell <= r_dwell;
    end
  end

  // Fold the current column's rows into the running scan classification.
  always_comb begin
    w_low     = ~r_row_sync;
    w_first   = (r_col == 4'b1110);
    w_one_low = (w_low != 4'h0) && ((w_low & (w_low - 4'd1)) == 4'h0);
    if (w_first) begin
      w_any_prev   = 1'b0;
      w_multi_prev = 1'b0;
    end else begin
      w_any_prev   = r_acc_any;
      w_multi_prev = r_acc_multi;
    end
    w_acc_any   = w_any_prev | (w_low != 4'h0);
    w_acc_multi = w_multi_prev | ((w_low != 4'h0) && (w_any_prev || !w_one_low));
    if ((w_low != 4'h0) && !w_any_prev) begin
      w_acc_code = key_map(col_index(r_col), row_index(w_low));
    end else begin
      w_acc_code = r_acc_code;
    end
  end

  // Sample rows on each terminal count; publish the result after column 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_any     <= 1'b0;
      r_acc_multi   <= 1'b0;
      r_acc_code    <= 4'h0;
      r_scan_valid  <= 1'b0;
      r_scan_single <= 1'b0;
      r_scan_code   <= 4'h0;
    end else begin
      r_scan_valid <= 1'b0;
      if (w_term) begin
        r_acc_any   <= w_acc_any;
        r_acc_multi <= w_acc_multi;
        r_acc_code  <= w_acc_code;
        if (r_col == 4'b0111) begin
          r_scan_valid  <= 1'b1;
          r_scan_single <= w_acc_any && !w_acc_multi;
          r_scan_code   <= w_acc_code;
        end
      end
    end
  end

  assign w_match_cand = r_scan_single && (r_scan_code == r_cand);
  assign w_match_dec  = r_scan_single && (r_scan_code == r_decode);

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_cand  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Debounce FSM next state, evaluated once per completed scan.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    w_rel_evt   = 1'b0;
    if (r_scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (r_scan_single) begin
            w_cand_nxt = r_scan_code;
            if (DEB_LAST == 4'd0) begin
              w_state_nxt = ST_PRESSED;
              w_cnt_nxt   = 4'd0;
              w_accept    = 1'b1;
            end else begin
              w_state_nxt = ST_PRESS_PEND;
              w_cnt_nxt   = 4'd1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        ST_PRESS_PEND: begin
          if (w_match_cand) begin
            if (r_cnt >= DEB_LAST) begin
              w_state_nxt = ST_PRESSED;
              w_cnt_nxt   = 4'd0;
              w_accept    = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else if (r_scan_single) begin
            w_cand_nxt = r_scan_code;
            w_cnt_nxt  = 4'd1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (w_match_dec) begin
            w_state_nxt = ST_PRESSED;
          end else if (DEB_LAST == 4'd0) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_rel_evt   = 1'b1;
          end else begin
            w_state_nxt = ST_REL_PEND;
            w_cnt_nxt   = 4'd1;
          end
        end
        ST_REL_PEND: begin
          if (w_match_dec) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = 4'd0;
          end else if (r_cnt >= DEB_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_rel_evt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned    REP_W    = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

  logic [REP_W-1:0] r_rep_cnt, w_rep_nxt;

  // Auto-repeat: count matching scans while held; clear on any other scan.
  always_comb begin
    w_rep_fire = 1'b0;
    w_rep_nxt  = r_rep_cnt;
    if (r_scan_valid && (r_state == ST_PRESSED) && w_match_dec) begin
      if (r_rep_cnt == REP_LAST) begin
        w_rep_fire = 1'b1;
        w_rep_nxt  = '0;
      end else begin
        w_rep_nxt = r_rep_cnt + REP_W'(1);
      end
    end else if (r_scan_valid) begin
      w_rep_nxt = '0;
    end else begin
      w_rep_nxt = r_rep_cnt;
    end
  end

  // Auto-repeat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= w_rep_nxt;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Output decode from FSM decisions.
  always_comb begin
    w_pulse_nxt   = w_accept | w_rep_fire;
    w_release_nxt = w_rel_evt;
    if (w_accept) begin
      w_valid_nxt  = 1'b1;
      w_decode_nxt = r_scan_code;
    end else if (w_rel_evt) begin
      w_valid_nxt  = 1'b0;
      w_decode_nxt = r_decode;
    end else begin
      w_valid_nxt  = r_key_valid;
      w_decode_nxt = r_decode;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decode      <= 4'h0;
      r_key_valid   <= 1'b0;
      r_key_pulse   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_decode      <= w_decode_nxt;
      r_key_valid   <= w_valid_nxt;
      r_key_pulse   <= w_pulse_nxt;
      r_key_release <= w_release_nxt;
    end
  end

  assign col         = r_col;
  assign decode      = r_decode;
  assign key_valid   = r_key_valid;
  assign key_pulse   = r_key_pulse;
  assign key_release = r_key_release;

endmodule
